// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared state encodings and widths for the ALU command sequencer
package alu_seq_pkg;

  localparam int OPCODE_W = 2;
  localparam int DATA_W   = 4;

  // 2'b11 is unused and decodes back to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_HOLD = 2'b10
  } seq_state_t;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - single-outstanding command sequencer for an external 4-bit ALU
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   cmd_valid_in/ready_out    command handshake (ready only in IDLE)
//   opcode_in, a_in, b_in     command fields
//   chain_in                  use the last result in place of a_in
//   opcode_out, a_out, b_out  registered operands driven to the ALU
//   y_in                      combinational ALU result
//   res_valid_out/ready_in    result handshake (valid only in HOLD)
//   res_out                   registered result
//   op_count_out              results consumed, wraps modulo 2^CNT_W
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid_in,
  output logic                cmd_ready_out,
  input  logic [OPCODE_W-1:0] opcode_in,
  input  logic [DATA_W-1:0]   a_in,
  input  logic [DATA_W-1:0]   b_in,
  input  logic                chain_in,
  output logic [OPCODE_W-1:0] opcode_out,
  output logic [DATA_W-1:0]   a_out,
  output logic [DATA_W-1:0]   b_out,
  input  logic [DATA_W-1:0]   y_in,
  output logic                res_valid_out,
  input  logic                res_ready_in,
  output logic [DATA_W-1:0]   res_out,
  output logic [CNT_W-1:0]    op_count_out
);

  seq_state_t state_q;
  seq_state_t state_d;

  logic [OPCODE_W-1:0] opcode_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   res_q;
  logic [DATA_W-1:0]   last_q;
  logic [CNT_W-1:0]    count_q;

  logic cmd_accept;
  logic res_accept;

  assign cmd_accept = (state_q == ST_IDLE) && cmd_valid_in;
  assign res_accept = (state_q == ST_HOLD) && res_ready_in;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; EXEC always lasts one cycle so the ALU can settle
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = cmd_valid_in ? ST_EXEC : ST_IDLE;
      ST_EXEC: state_d = ST_HOLD;
      ST_HOLD: state_d = res_ready_in ? ST_IDLE : ST_HOLD;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs depend on registered state only
  always_comb begin
    cmd_ready_out = 1'b0;
    res_valid_out = 1'b0;
    case (state_q)
      ST_IDLE: cmd_ready_out = 1'b1;
      ST_HOLD: res_valid_out = 1'b1;
      default: begin
        cmd_ready_out = 1'b0;
        res_valid_out = 1'b0;
      end
    endcase
  end

  // Operand, result and counter registers. Operands only change on
  // acceptance, so commands offered outside IDLE leave them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      last_q   <= '0;
      count_q  <= '0;
    end else begin
      if (cmd_accept) begin
        opcode_q <= opcode_in;
        a_q      <= chain_in ? last_q : a_in;
        b_q      <= b_in;
      end
      if (state_q == ST_EXEC) begin
        res_q  <= y_in;
        last_q <= y_in;
      end
      if (res_accept) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign opcode_out   = opcode_q;
  assign a_out        = a_q;
  assign b_out        = b_q;
  assign res_out      = res_q;
  assign op_count_out = count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [1:0] opcode;
  logic [3:0] a_val;
  logic [3:0] b_val;
  logic       chain;
  logic       res_ready;
  logic [3:0] y;

  logic       cmd_ready, res_valid;
  logic [1:0] opcode_o;
  logic [3:0] a_o, b_o, res_o;
  logic [7:0] count8;

  logic       cmd_ready2, res_valid2;
  logic [1:0] opcode_o2;
  logic [3:0] a_o2, b_o2, res_o2;
  logic [1:0] count2;

  logic       force_en;
  logic [3:0] force_val;

  int total = 0;
  int bad   = 0;

  logic [3:0] last_m;
  int         cnt8_m;
  int         cnt2_m;

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign y = force_en ? force_val : alu_f(opcode_o, a_o, b_o);

  alu_cmd_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready),
    .opcode_in(opcode), .a_in(a_val), .b_in(b_val), .chain_in(chain),
    .opcode_out(opcode_o), .a_out(a_o), .b_out(b_o),
    .y_in(y),
    .res_valid_out(res_valid), .res_ready_in(res_ready),
    .res_out(res_o), .op_count_out(count8)
  );

  alu_cmd_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready2),
    .opcode_in(opcode), .a_in(a_val), .b_in(b_val), .chain_in(chain),
    .opcode_out(opcode_o2), .a_out(a_o2), .b_out(b_o2),
    .y_in(y),
    .res_valid_out(res_valid2), .res_ready_in(res_ready),
    .res_out(res_o2), .op_count_out(count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full command: accept, EXEC, HOLD for 'hold' stalled cycles, consume.
  // With poke set, a bogus command (a=9) is offered during EXEC.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic ch, input int hold, input logic poke);
    logic [3:0] ea;
    logic [3:0] ey;
    ea = ch ? last_m : a;
    ey = force_en ? force_val : alu_f(op, ea, b);
    cmd_valid = 1'b1; opcode = op; a_val = a; b_val = b; chain = ch;
    chk("ready_before_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0; chain = 1'b0;
    chk("opcode_out", opcode_o, op);
    chk("a_out", a_o, ea);
    chk("b_out", b_o, b);
    chk("ready_in_exec", cmd_ready, 0);
    chk("valid_in_exec", res_valid, 0);
    if (poke) begin
      cmd_valid = 1'b1; a_val = 4'd9; chain = 1'b0;
    end
    tick();
    cmd_valid = 1'b0;
    chk("valid_in_hold", res_valid, 1);
    chk("res_out", res_o, ey);
    if (poke) chk("a_out_after_poke", a_o, ea);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("bp_valid", res_valid, 1);
      chk("bp_res", res_o, ey);
      chk("bp_ready", cmd_ready, 0);
      chk("bp_count", count8, cnt8_m[7:0]);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    last_m = ey;
    cnt8_m = (cnt8_m + 1) % 256;
    cnt2_m = (cnt2_m + 1) % 4;
    chk("count8", count8, cnt8_m[7:0]);
    chk("count2", count2, cnt2_m[1:0]);
    chk("ready_after_consume", cmd_ready, 1);
    chk("valid_after_consume", res_valid, 0);
    chk("a_out_held", a_o, ea);
    if (poke) begin
      tick();
      chk("poke_not_queued", cmd_ready, 1);
      chk("poke_count", count8, cnt8_m[7:0]);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; opcode = '0; a_val = '0; b_val = '0;
    chain = 1'b0; res_ready = 1'b0; force_en = 1'b0; force_val = '0;
    last_m = '0; cnt8_m = 0; cnt2_m = 0;
    tick();
    tick();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_valid", res_valid, 0);
    chk("rst_res", res_o, 0);
    chk("rst_count", count8, 0);
    chk("rst_a_out", a_o, 0);
    chk("rst_b_out", b_o, 0);
    chk("rst_opcode_out", opcode_o, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_release", cmd_ready, 1);

    // Single command with a fixed ALU answer
    force_en = 1'b1; force_val = 4'hA;
    run_cmd(2'b01, 4'd3, 4'd5, 1'b0, 0, 1'b0);

    // Backpressure for five cycles
    force_val = 4'h6;
    run_cmd(2'b10, 4'd1, 4'd2, 1'b0, 5, 1'b0);

    // Chaining: second command must use 7, not F
    force_val = 4'h7;
    run_cmd(2'b00, 4'd4, 4'd4, 1'b0, 0, 1'b0);
    force_val = 4'h2;
    run_cmd(2'b11, 4'hF, 4'd1, 1'b1, 1, 1'b0);

    // Command offered during EXEC is ignored
    force_en = 1'b0;
    run_cmd(2'b00, 4'd2, 4'd6, 1'b0, 0, 1'b1);

    // Reset while in HOLD
    cmd_valid = 1'b1; opcode = 2'b00; a_val = 4'd5; b_val = 4'd5; chain = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("pre_rst_valid", res_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_m = '0; cnt8_m = 0; cnt2_m = 0;
    chk("midrst_valid", res_valid, 0);
    chk("midrst_res", res_o, 0);
    chk("midrst_count", count8, 0);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_a_out", a_o, 0);

    // Counter wrap on the CNT_W=2 instance: 1,2,3,0
    for (int i = 0; i < 4; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 1'($urandom), 0, 1'b0);
    end
    chk("wrap_count2_zero", count2, 0);
    chk("wrap_count8_four", count8, 4);

    // Randomized commands against the model
    for (int i = 0; i < 24; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
              1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
